// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the sequential signed multiply/divide unit.
// Pure definitions; no timing or flow control of its own.
package muldiv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER);

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: signed shift-add for MULT, restoring step on magnitudes for DIV.
// Zero latency; no flow control, the caller sequences the iterations.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        op,
    input  logic        last,
    input  logic [31:0] part_hi,
    input  logic [31:0] part_lo,
    input  logic [31:0] operand,
    output logic [31:0] next_hi,
    output logic [31:0] next_lo
);

    logic [32:0] sum;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        // The multiplier's sign bit carries weight -2^31, so the final step subtracts.
        sum = {part_hi[31], part_hi};
        if (part_lo[0]) begin
            if (last) begin
                sum = sum - {operand[31], operand};
            end else begin
                sum = sum + {operand[31], operand};
            end
        end

        shifted = {part_hi, part_lo[31]};
        diff    = shifted - {1'b0, operand};

        next_hi = part_hi;
        next_lo = part_lo;
        if (op == OP_MULT) begin
            next_hi = sum[32:1];
            next_lo = {sum[0], part_lo[31:1]};
        end else if (!diff[32]) begin
            next_hi = diff[31:0];
            next_lo = {part_lo[30:0], 1'b1};
        end else begin
            next_hi = shifted[31:0];
            next_lo = {part_lo[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative signed 32x32 MULT/DIV into HI/LO; 33 cycles start-to-done, 1 cycle for divide-by-zero.
// No backpressure: start is ignored while busy or finishing, abort cancels an operation in flight.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic        abort,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        work_hi_q, work_hi_d;
    logic [31:0]        work_lo_q, work_lo_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;

    logic               last;
    logic [31:0]        step_opnd;
    logic [31:0]        step_hi;
    logic [31:0]        step_lo;

    assign last      = (cnt_q == CNT_W'(ITER - 1));
    assign step_opnd = (op_q == OP_DIV) ? abs32(b_q) : a_q;

    muldiv_step u_step (
        .op      (op_q),
        .last    (last),
        .part_hi (work_hi_q),
        .part_lo (work_lo_q),
        .operand (step_opnd),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    op_d      = op;
                    cnt_d     = '0;
                    work_hi_d = '0;
                    work_lo_d = (op == OP_DIV) ? abs32(a) : b;
                    if (op == OP_DIV && b == 32'd0) begin
                        state_d    = S_FIN;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d = (op == OP_DIV) ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    work_hi_d = step_hi;
                    work_lo_d = step_lo;
                    cnt_d     = cnt_q + 1'b1;
                    if (last) begin
                        state_d = S_FIN;
                        if (op_q == OP_MULT) begin
                            hi_d = step_hi;
                            lo_d = step_lo;
                        end else begin
                            // Quotient negative iff signs differ; remainder follows the dividend.
                            lo_d = (a_q[31] ^ b_q[31]) ? (~step_lo + 32'd1) : step_lo;
                            hi_d = a_q[31] ? (~step_hi + 32'd1) : step_hi;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            work_hi_q  <= '0;
            work_lo_q  <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, corner sequences, random vs arithmetic model.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    // Reference model state: last HI/LO the block should be holding.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .abort    (abort),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        int          elat;
        logic        edz;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Plain arithmetic reference: returns {hi, lo} after an operation.
    function automatic logic [63:0] model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                         input logic [31:0] ph, input logic [31:0] pl);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 1'b0) begin
            p = sx * sy;
            return p;
        end
        if (y == 32'd0) return {ph, pl};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one op; optionally inject a second start and/or an abort in a given cycle.
    task automatic run(input logic o, input logic [31:0] x, input logic [31:0] y, input logic ab0,
                       input int inj_start, input int inj_abort, output int lat, output logic dz);
        int   n;
        logic got;
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; abort = ab0;
        n = 0; got = 1'b0; lat = -1; dz = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0; abort = 1'b0;
            if (done) begin
                got = 1'b1; lat = n; dz = div_zero;
                chk("busy_in_fin", {63'd0, busy}, 64'd0);
            end
            if (inj_abort > 0 && n == inj_abort + 1) chk("abort_busy", {63'd0, busy}, 64'd0);
            if (n == inj_start) begin start = 1'b1; op = ~o; a = ~x; b = y + 32'd5; end
            if (n == inj_abort) abort = 1'b1;
        end
        if (got) begin
            @(posedge clk); #1;
            chk("done_one_cycle", {63'd0, done}, 64'd0);
        end
    endtask

    initial begin
        int          lat;
        logic        dz;
        logic [63:0] exp;
        logic        ro;
        logic [31:0] ra, rb;
        int          elat;

        tv[0] = '{1'b0, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 33, 1'b0};
        tv[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 1'b0};
        tv[2] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1'b0};
        tv[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 1'b0};
        tv[4] = '{1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 33, 1'b0};
        tv[5] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 33, 1'b0};
        tv[6] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, 1'b0};
        tv[7] = '{1'b0, 32'h33333333, 32'h55555556, 32'h11111111, 32'h22222222, 33, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz",   {63'd0, div_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(tv[i].op, tv[i].a, tv[i].b, 1'b0, 0, 0, lat, dz);
            chk($sformatf("vec%0d_lat", i), lat, tv[i].elat);
            chk($sformatf("vec%0d_dz", i), {63'd0, dz}, {63'd0, tv[i].edz});
            chk($sformatf("vec%0d_hilo", i), {hi, lo}, {tv[i].ehi, tv[i].elo});
        end
        m_hi = 32'h11111111; m_lo = 32'h22222222;

        // Divide by zero leaves the previous HI/LO in place.
        run(1'b1, 32'd5, 32'd0, 1'b0, 0, 0, lat, dz);
        chk("dz_lat", lat, 1);
        chk("dz_flag", {63'd0, dz}, 64'd1);
        chk("dz_hilo", {hi, lo}, {32'h11111111, 32'h22222222});

        // Second start mid-operation is ignored.
        run(1'b0, 32'h00000003, 32'hFFFFFFFC, 1'b0, 5, 0, lat, dz);
        chk("ign_start_lat", lat, 33);
        chk("ign_start_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF4});

        // Abort in cycle 10: no done, HI/LO untouched.
        run(1'b1, 32'd1000, 32'd3, 1'b0, 0, 10, lat, dz);
        chk("abort_nodone", lat, -1);
        chk("abort_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF4});

        // start and abort together in IDLE: start wins.
        run(1'b0, 32'd6, 32'd7, 1'b1, 0, 0, lat, dz);
        chk("start_abort_lat", lat, 33);
        chk("start_abort_hilo", {hi, lo}, 64'd42);

        // Reset in cycle 20 of a DIV.
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        run(1'b0, 32'h00010000, 32'h00010000, 1'b0, 0, 0, lat, dz);
        chk("postrst_lat", lat, 33);
        chk("postrst_hilo", {hi, lo}, {32'h00000001, 32'h00000000});
        m_hi = 32'h00000001; m_lo = 32'h00000000;

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 9);
                2: ra = $urandom_range(0, 200);
                3: rb = -$urandom_range(1, 9);
                default: ;
            endcase
            exp  = model(ro, ra, rb, m_hi, m_lo);
            elat = (ro && rb == 32'd0) ? 1 : 33;
            run(ro, ra, rb, 1'b0, 0, 0, lat, dz);
            chk($sformatf("rnd%0d_lat", i), lat, elat);
            chk($sformatf("rnd%0d_dz", i), {63'd0, dz}, {63'd0, (ro && rb == 32'd0)});
            chk($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", i, ro, ra, rb), {hi, lo}, exp);
            m_hi = exp[63:32]; m_lo = exp[31:0];
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 start  input  1  one-cycle request from the control unit to begin an operation.
REQ-005 op  input  1  operation select: 0 = MULT (signed), 1 = DIV (signed).
REQ-006 abort  input  1  exception-driven cancel of an operation in flight.
REQ-007 a  input  32  operand from Reg_A (multiplicand or dividend).
REQ-008 b  input  32  operand from Reg_B (multiplier or divisor).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse when an operation completes or is rejected.
REQ-011 div_zero  output  1  one-cycle pulse, coincident with done, when a DIV is attempted with b == 0.
REQ-012 hi  output  32  HI register contents.
REQ-013 lo  output  32  LO register contents.

Function
REQ-014 States SHALL be IDLE, MUL, DIV and FIN.
REQ-015 In IDLE with start=1, the block SHALL latch a, b and op on that edge and move to MUL (op=0) or DIV (op=1), with the iteration counter set to 0.
REQ-016 start SHALL be ignored in every state other than IDLE; operands already latched SHALL NOT change.
REQ-017 MUL SHALL perform one signed shift-add iteration per cycle for 32 cycles, producing the 64-bit product {hi, lo} = a*b (two's complement).
REQ-018 DIV SHALL perform one restoring iteration per cycle on operand magnitudes for 32 cycles, then sign-correct the results: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0x00000000.
REQ-020 On DIV with b == 0 at the start edge, the block SHALL skip iteration and enter FIN on the next edge; hi and lo SHALL remain unchanged and div_zero SHALL pulse together with done.
REQ-021 When the counter reaches 31, the next edge SHALL enter FIN and write the results to hi and lo.
REQ-022 In FIN, done SHALL be 1 for exactly one cycle, after which the block SHALL return to IDLE; results SHALL be visible from that cycle onward.
REQ-023 Latency from the start edge to the done cycle SHALL be 33 cycles for a valid operation and 1 cycle for divide-by-zero.
REQ-024 busy SHALL be 1 in MUL and DIV and 0 in IDLE and FIN.
REQ-025 hi and lo SHALL change only on result write-back or reset; intermediate values SHALL live in internal working registers.
REQ-026 abort=1 in MUL or DIV SHALL return the block to IDLE on the next edge with no done pulse and hi/lo unchanged; abort SHALL be ignored in IDLE and FIN.
REQ-027 If start and abort are both high in IDLE, start SHALL win.

Reset
REQ-028 Reset SHALL place the block in IDLE and clear the counter; busy, done and div_zero SHALL be 0, and hi, lo and all working registers SHALL be 0x00000000.
REQ-029 Reset SHALL take priority over start and abort, including in the middle of an operation.

Structure
REQ-030 The package muldiv_pkg SHALL hold the state encoding, the op encoding (OP_MULT=0, OP_DIV=1) and the constant ITER=32.
REQ-031 The per-cycle arithmetic step SHALL be a combinational sub-module named muldiv_step, with inputs op, partial remainder/product and operand, and outputs the next partial values.
REQ-032 The FSM, counter and the hi/lo registers SHALL reside in muldiv_seq.

Verification
REQ-033 MULT a=3, b=0xFFFFFFFC -> done 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-034 DIV a=7, b=0xFFFFFFFE -> done at cycle 33; lo=0xFFFFFFFD, hi=0x00000001; DIV a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 DIV a=5, b=0 with prior hi/lo = 0x11111111/0x22222222 -> done and div_zero high 1 cycle after start; hi/lo unchanged.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 MULT started, second start at cycle 5 with different operands -> ignored; first result correct at cycle 33; abort at cycle 10 of a later op -> IDLE, no done, hi/lo unchanged.
REQ-038 reset asserted at cycle 20 of a DIV -> next cycle busy=0, hi=lo=0; a new MULT 0x10000 * 0x10000 then gives hi=1, lo=0.
